// File: rtl/mycpu_exe_stage_if.sv
// mycpu_exe_stage_if: data-SRAM address channel
// master issues the request, slave answers with addr_ok
interface mycpu_exe_stage_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        output data_wstrb,
        input  data_addr_ok
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        input  data_wstrb,
        output data_addr_ok
    );
endinterface

// File: rtl/mycpu_exe_stage.sv
// mycpu_exe_stage: MIPS execute stage
// ALU drive, exception detect, data-SRAM address request
module mycpu_exe_stage #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [4:0] EXC_OV     = 5'h0C,
    parameter logic [4:0] EXC_ADEL   = 5'h04,
    parameter logic [4:0] EXC_ADES   = 5'h05
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  ds_to_es_valid,
    output logic                  es_allowin,
    input  logic [31:0]           ds_pc,
    input  logic [3:0]            ds_alu_op,
    input  logic [DATA_WIDTH-1:0] ds_src1,
    input  logic [DATA_WIDTH-1:0] ds_src2,
    input  logic                  ds_ov_en,
    input  logic                  ds_mem_re,
    input  logic                  ds_mem_we,
    input  logic [1:0]            ds_mem_size,
    input  logic [DATA_WIDTH-1:0] ds_store_data,
    input  logic [4:0]            ds_dest,
    input  logic                  ds_gr_we,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    mycpu_exe_stage_if.master     dbus,
    input  logic                  ms_allowin,
    output logic                  es_to_ms_valid,
    output logic [31:0]           es_pc,
    output logic [DATA_WIDTH-1:0] es_result,
    output logic [4:0]            es_dest,
    output logic                  es_gr_we,
    output logic                  es_mem_re,
    output logic                  es_ex,
    output logic [4:0]            es_excode,
    output logic [31:0]           es_badvaddr,
    output logic                  es_fwd_valid,
    output logic [4:0]            es_fwd_dest,
    output logic [DATA_WIDTH-1:0] es_fwd_data,
    output logic                  es_fwd_is_load
);

    typedef struct packed {
        logic [31:0]           pc;
        logic [3:0]            alu_op;
        logic [DATA_WIDTH-1:0] src1;
        logic [DATA_WIDTH-1:0] src2;
        logic                  ov_en;
        logic                  mem_re;
        logic                  mem_we;
        logic [1:0]            mem_size;
        logic [DATA_WIDTH-1:0] store_data;
        logic [4:0]            dest;
        logic                  gr_we;
    } es_bus_t;

    es_bus_t               es_r;
    es_bus_t               ds_bus;
    logic                  es_valid;
    logic                  addr_acked;
    logic                  is_mem;
    logic                  ov_trap;
    logic                  misalign;
    logic                  addr_err;
    logic                  es_ready_go;
    logic                  req;
    logic [3:0]            wstrb;
    logic [DATA_WIDTH-1:0] wdata;

    assign ds_bus = '{
        pc:         ds_pc,
        alu_op:     ds_alu_op,
        src1:       ds_src1,
        src2:       ds_src2,
        ov_en:      ds_ov_en,
        mem_re:     ds_mem_re,
        mem_we:     ds_mem_we,
        mem_size:   ds_mem_size,
        store_data: ds_store_data,
        dest:       ds_dest,
        gr_we:      ds_gr_we
    };

    assign alu_a  = es_r.src1;
    assign alu_b  = es_r.src2;
    assign alu_op = es_r.alu_op;

    assign is_mem   = es_r.mem_re | es_r.mem_we;
    assign ov_trap  = es_r.ov_en & alu_overflow;
    assign addr_err = is_mem & misalign;
    assign es_ex    = es_valid & (ov_trap | addr_err);

    // alignment check of the effective address by access size
    always_comb begin
        misalign = 1'b0;
        unique case (es_r.mem_size)
            2'd1:    misalign = alu_result[0];
            2'd2:    misalign = |alu_result[1:0];
            default: misalign = 1'b0;
        endcase
    end

    // overflow outranks the address error
    always_comb begin
        es_excode = 5'h00;
        if (es_valid) begin
            if (ov_trap)
                es_excode = EXC_OV;
            else if (addr_err)
                es_excode = es_r.mem_re ? EXC_ADEL : EXC_ADES;
        end
    end

    assign es_badvaddr =
        (es_valid && addr_err && !ov_trap) ? alu_result : 32'h0;

    assign req = es_valid & is_mem & ~es_ex & ~flush & ~addr_acked;

    assign es_ready_go = ~is_mem | es_ex | addr_acked
                       | (req & dbus.data_addr_ok);

    assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid & es_ready_go & ~flush;

    // byte-lane enables and replicated write data
    always_comb begin
        wstrb = 4'b1111;
        wdata = es_r.store_data;
        unique case (es_r.mem_size)
            2'd0: begin
                wstrb = 4'b0001 << alu_result[1:0];
                wdata = {4{es_r.store_data[7:0]}};
            end
            2'd1: begin
                wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata = {2{es_r.store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = es_r.store_data;
            end
        endcase
    end

    assign dbus.data_req   = req;
    assign dbus.data_wr    = es_r.mem_we;
    assign dbus.data_size  = es_r.mem_size;
    assign dbus.data_addr  = alu_result;
    assign dbus.data_wdata = wdata;
    assign dbus.data_wstrb = wstrb;

    assign es_pc     = es_r.pc;
    assign es_result = alu_result;
    assign es_dest   = es_r.dest;
    assign es_gr_we  = es_r.gr_we & ~es_ex;
    assign es_mem_re = es_r.mem_re;

    assign es_fwd_valid   = es_valid & es_gr_we;
    assign es_fwd_dest    = es_r.dest;
    assign es_fwd_data    = alu_result;
    assign es_fwd_is_load = es_r.mem_re;

    // stage occupancy; flush kills the held instruction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            es_valid <= 1'b0;
        else if (flush)
            es_valid <= 1'b0;
        else if (es_allowin)
            es_valid <= ds_to_es_valid;
    end

    // remembers the accepted address so only one request is made
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            addr_acked <= 1'b0;
        else if (flush || es_allowin)
            addr_acked <= 1'b0;
        else if (req && dbus.data_addr_ok)
            addr_acked <= 1'b1;
    end

    // instruction bundle captured from decode
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            es_r <= '0;
        else if (ds_to_es_valid && es_allowin)
            es_r <= ds_bus;
    end

endmodule

// File: tb/tb_mycpu_exe_stage.sv
// tb_mycpu_exe_stage: directed bench with a cycle model
// of the execute stage and an adder/subtractor ALU
module tb_mycpu_exe_stage;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        ov_en;
        logic        re;
        logic        we;
        logic [1:0]  size;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic        gr_we;
    } ins_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic flush = 1'b0;
    logic ds_valid = 1'b0;
    logic ms_allowin = 1'b1;
    logic addr_ok = 1'b0;
    ins_t cur;

    logic        es_allowin, alu_overflow, es_to_ms_valid;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic [31:0] es_pc, es_result, es_badvaddr, es_fwd_data;
    logic [4:0]  es_dest, es_excode, es_fwd_dest;
    logic        es_gr_we, es_mem_re, es_ex;
    logic        es_fwd_valid, es_fwd_is_load;

    int tests = 0;
    int fails = 0;

    mycpu_exe_stage_if dbus_if ();
    assign dbus_if.data_addr_ok = addr_ok;

    always #5 clk = ~clk;

    // ALU environment: op 1 subtracts, everything else adds
    assign alu_result = (alu_op == 4'd1) ? alu_a - alu_b : alu_a + alu_b;
    assign alu_overflow = (alu_op == 4'd1)
        ? ((alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]))
        : ((alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]));

    mycpu_exe_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .ds_to_es_valid (ds_valid),
        .es_allowin     (es_allowin),
        .ds_pc          (cur.pc),
        .ds_alu_op      (cur.op),
        .ds_src1        (cur.s1),
        .ds_src2        (cur.s2),
        .ds_ov_en       (cur.ov_en),
        .ds_mem_re      (cur.re),
        .ds_mem_we      (cur.we),
        .ds_mem_size    (cur.size),
        .ds_store_data  (cur.sd),
        .ds_dest        (cur.dest),
        .ds_gr_we       (cur.gr_we),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_op         (alu_op),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow),
        .dbus           (dbus_if),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_pc          (es_pc),
        .es_result      (es_result),
        .es_dest        (es_dest),
        .es_gr_we       (es_gr_we),
        .es_mem_re      (es_mem_re),
        .es_ex          (es_ex),
        .es_excode      (es_excode),
        .es_badvaddr    (es_badvaddr),
        .es_fwd_valid   (es_fwd_valid),
        .es_fwd_dest    (es_fwd_dest),
        .es_fwd_data    (es_fwd_data),
        .es_fwd_is_load (es_fwd_is_load)
    );

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic ins_t mk(input logic [31:0] pc,
                                input logic [3:0] op,
                                input logic [31:0] s1,
                                input logic [31:0] s2,
                                input logic ov_en,
                                input logic re,
                                input logic we,
                                input logic [1:0] size,
                                input logic [31:0] sd,
                                input logic [4:0] dest,
                                input logic gr_we);
        ins_t r;
        r.pc = pc; r.op = op; r.s1 = s1; r.s2 = s2;
        r.ov_en = ov_en; r.re = re; r.we = we; r.size = size;
        r.sd = sd; r.dest = dest; r.gr_we = gr_we;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    ins_t        m_ins;
    logic        m_valid = 1'b0;
    logic        m_acked = 1'b0;
    logic [31:0] e_addr;
    logic        e_ovt, e_mis, e_ex, e_req, e_go, e_allow, e_mem;

    task automatic model_eval();
        longint sr;
        longint lim;
        int nb;
        lim = 2147483647;
        if (m_ins.op == 4'd1)
            sr = longint'($signed(m_ins.s1)) - longint'($signed(m_ins.s2));
        else
            sr = longint'($signed(m_ins.s1)) + longint'($signed(m_ins.s2));
        e_addr = sr[31:0];
        e_ovt = m_ins.ov_en && (sr > lim || sr < -lim - 1);
        e_mem = m_ins.re || m_ins.we;
        nb = 1 << m_ins.size;
        e_mis = e_mem && (m_ins.size != 2'd3)
             && ((int'(e_addr[1:0]) % nb) != 0);
        e_ex = m_valid && (e_ovt || e_mis);
        e_req = m_valid && e_mem && !e_ex && !flush && !m_acked;
        e_go = !e_mem || e_ex || m_acked || (e_req && addr_ok);
        e_allow = !m_valid || (e_go && ms_allowin);
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid = 1'b0;
            m_acked = 1'b0;
            m_ins = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end else begin
            model_eval();
            if (flush) begin
                m_valid = 1'b0;
                m_acked = 1'b0;
            end else if (e_allow) begin
                m_valid = ds_valid;
                m_acked = 1'b0;
            end else if (e_req && addr_ok) begin
                m_acked = 1'b1;
            end
            if (ds_valid && e_allow)
                m_ins = cur;
        end
    end

    // compare every output against the model on the falling edge
    always @(negedge clk) begin
        logic [3:0]  xs;
        logic [31:0] xd;
        int nb;
        model_eval();
        chk("allowin", es_allowin, e_allow);
        chk("to_ms_valid", es_to_ms_valid, m_valid && e_go && !flush);
        chk("alu_a", alu_a, m_ins.s1);
        chk("alu_b", alu_b, m_ins.s2);
        chk("alu_op", alu_op, m_ins.op);
        chk("es_pc", es_pc, m_ins.pc);
        chk("es_result", es_result, e_addr);
        chk("es_dest", es_dest, m_ins.dest);
        chk("es_gr_we", es_gr_we, m_ins.gr_we && !e_ex);
        chk("es_mem_re", es_mem_re, m_ins.re);
        chk("es_ex", es_ex, e_ex);
        if (e_ex)
            chk("es_excode", es_excode,
                e_ovt ? 5'h0C : (m_ins.re ? 5'h04 : 5'h05));
        chk("badvaddr", es_badvaddr,
            (m_valid && e_mis && !e_ovt) ? e_addr : 32'h0);
        chk("data_req", dbus_if.data_req, e_req);
        if (e_req) begin
            nb = 1 << m_ins.size;
            xs = 4'(((1 << nb) - 1) << e_addr[1:0]);
            if (m_ins.size == 2'd0)
                xd = {24'h0, m_ins.sd[7:0]} * 32'h01010101;
            else if (m_ins.size == 2'd1)
                xd = {16'h0, m_ins.sd[15:0]} * 32'h00010001;
            else
                xd = m_ins.sd;
            chk("data_addr", dbus_if.data_addr, e_addr);
            chk("data_wr", dbus_if.data_wr, m_ins.we);
            chk("data_size", dbus_if.data_size, m_ins.size);
            chk("data_wstrb", dbus_if.data_wstrb, xs);
            chk("data_wdata", dbus_if.data_wdata, xd);
        end
        if (!e_ex)
            chk("fwd_valid", es_fwd_valid, m_valid && m_ins.gr_we);
        chk("fwd_dest", es_fwd_dest, m_ins.dest);
        chk("fwd_data", es_fwd_data, e_addr);
        chk("fwd_is_load", es_fwd_is_load, m_ins.re);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input ins_t i);
        cur = i;
        ds_valid = 1'b1;
        step();
        ds_valid = 1'b0;
    endtask

    initial begin
        int reqc, hs, lowc;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_allowin", es_allowin, 1);
        chk("rst_req", dbus_if.data_req, 0);
        chk("rst_pc", es_pc, 0);

        // ADDU wraps without a trap
        cap(mk(32'h100, 0, 32'h7FFFFFFF, 1, 0, 0, 0, 2, 0, 2, 1));
        @(negedge clk);
        chk("addu_res", es_result, 32'h80000000);
        chk("addu_ex", es_ex, 0);
        chk("addu_to_ms", es_to_ms_valid, 1);

        // ADD traps
        cap(mk(32'h104, 0, 32'h7FFFFFFF, 1, 1, 0, 0, 2, 0, 3, 1));
        @(negedge clk);
        chk("add_ex", es_ex, 1);
        chk("add_code", es_excode, 5'h0C);
        chk("add_gr_we", es_gr_we, 0);
        chk("add_req", dbus_if.data_req, 0);

        // SB at 0x1003, addr_ok after three wait cycles
        cap(mk(32'h108, 0, 32'h1000, 3, 0, 0, 1, 0, 32'hAB, 0, 0));
        reqc = 0; hs = 0; lowc = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) addr_ok = 1'b1;
            @(negedge clk);
            if (dbus_if.data_req) reqc++;
            if (dbus_if.data_req && addr_ok) hs++;
            if (!es_allowin) lowc++;
            chk("sb_wstrb", dbus_if.data_wstrb, 4'b1000);
            chk("sb_wdata", dbus_if.data_wdata, 32'hABABABAB);
            step();
        end
        addr_ok = 1'b0;
        @(negedge clk);
        chk("sb_req_after", dbus_if.data_req, 0);
        chk("sb_req_cycles", reqc, 4);
        chk("sb_handshakes", hs, 1);
        chk("sb_allowin_low", lowc, 3);

        // misaligned LW and SH
        cap(mk(32'h10C, 0, 32'h1000, 2, 0, 1, 0, 2, 0, 4, 1));
        @(negedge clk);
        chk("lw_ex", es_ex, 1);
        chk("lw_code", es_excode, 5'h04);
        chk("lw_bad", es_badvaddr, 32'h1002);
        chk("lw_req", dbus_if.data_req, 0);
        cap(mk(32'h110, 0, 32'h1000, 1, 0, 0, 1, 1, 32'h1234, 0, 0));
        @(negedge clk);
        chk("sh_code", es_excode, 5'h05);
        chk("sh_bad", es_badvaddr, 32'h1001);

        // LW accepted under memory-stage back-pressure
        cap(mk(32'h114, 0, 32'h2000, 0, 0, 1, 0, 2, 0, 5, 1));
        ms_allowin = 1'b0;
        addr_ok = 1'b1;
        hs = 0;
        @(negedge clk);
        chk("bp_req", dbus_if.data_req, 1);
        if (dbus_if.data_req && addr_ok) hs++;
        step();
        @(negedge clk);
        chk("bp_noreq", dbus_if.data_req, 0);
        chk("bp_allowin", es_allowin, 0);
        chk("bp_held_pc", es_pc, 32'h114);
        if (dbus_if.data_req && addr_ok) hs++;
        step();
        ms_allowin = 1'b1;
        addr_ok = 1'b0;
        @(negedge clk);
        chk("bp_go", es_to_ms_valid, 1);
        chk("bp_allowin2", es_allowin, 1);
        step();
        @(negedge clk);
        chk("bp_empty", es_to_ms_valid, 0);
        chk("bp_handshakes", hs, 1);

        // flush while a SW request is pending
        cap(mk(32'h118, 0, 32'h3000, 0, 0, 0, 1, 2,
               32'hDEADBEEF, 0, 0));
        @(negedge clk);
        chk("fl_req", dbus_if.data_req, 1);
        #1 flush = 1'b1;
        #1;
        chk("fl_req_drop", dbus_if.data_req, 0);
        chk("fl_to_ms", es_to_ms_valid, 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_allowin", es_allowin, 1);
        cap(mk(32'h11C, 0, 5, 6, 0, 0, 0, 2, 0, 6, 1));
        @(negedge clk);
        chk("fl_next_res", es_result, 32'd11);
        chk("fl_next_go", es_to_ms_valid, 1);

        // reset pulsed mid-request
        cap(mk(32'h120, 0, 32'h3004, 0, 0, 0, 1, 2, 32'h5, 0, 0));
        @(negedge clk);
        chk("rs_req", dbus_if.data_req, 1);
        #1 resetn = 1'b0;
        #1;
        chk("rs_req_drop", dbus_if.data_req, 0);
        chk("rs_pc", es_pc, 0);
        step();
        resetn = 1'b1;
        @(negedge clk);
        chk("rs_allowin", es_allowin, 1);
        cap(mk(32'h124, 0, 32'h3000, 1, 0, 1, 0, 0, 0, 7, 1));
        addr_ok = 1'b1;
        @(negedge clk);
        chk("lb_req", dbus_if.data_req, 1);
        chk("lb_addr", dbus_if.data_addr, 32'h3001);
        chk("lb_fwd_load", es_fwd_is_load, 1);
        step();
        addr_ok = 1'b0;
        @(negedge clk);
        chk("lb_done", dbus_if.data_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
